// File: rtl/fip_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fip_addsub_pipe
//
// Two-stage pipelined signed fixed-point adder/subtractor used between the
// vector-math stages of the raytracing datapath (ray-origin offsets, edge-
// function accumulation).
//
// The unit computes x + y or x - y on two's-complement WIDTH-bit operands.
// The fractional split (FRAC) is purely descriptive: addition is
// format-agnostic.
//
// Each result carries an overflow flag. A saturating counter tracks how many
// overflowed results have been handed to the consumer.
//
// Optional build macro:
//   FIP_ADDSUB_SAT_EN  - when defined, overflowed results clamp to the most
//                        positive / most negative value instead of wrapping.
//                        The overflow flag and the counter behave the same in
//                        both builds.
//
// Parameters:
//   WIDTH  operand/result width (two's complement)
//   FRAC   fractional bits (documentation only)
//   CNT_W  overflow event counter width
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   in_valid   operands present
//   in_ready   unit accepts operands this cycle (combinational from out_ready)
//   in_x/in_y  signed operands
//   in_sub     0: x+y, 1: x-y
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_res    signed result
//   out_ovf    overflow flag of out_res
//   ovf_cnt    saturating count of delivered overflowed results
//   ovf_clr    synchronous clear of ovf_cnt (wins over a concurrent count)
// ---------------------------------------------------------------------------
module fip_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  if (WIDTH < 2) begin : g_width_range
    $error("fip_addsub_pipe: WIDTH must be at least 2");
  end
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_range
    $error("fip_addsub_pipe: FRAC must lie in [0, WIDTH-1]");
  end

  // Full-precision sum/difference at WIDTH+1 bits.
  // Subtraction is x + ~y + 1, so y = most-negative is handled exactly.
  function automatic logic signed [WIDTH:0] add_sub(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic                    sub
  );
    logic signed [WIDTH:0] xe;
    logic signed [WIDTH:0] ye;
    xe = {x[WIDTH-1], x};
    ye = {y[WIDTH-1], y};
    return xe + (ye ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
  endfunction

  // The result does not fit in WIDTH bits when the two top bits of the
  // extended sum disagree.
  function automatic logic ovf_of(input logic signed [WIDTH:0] raw);
    return raw[WIDTH] ^ raw[WIDTH-1];
  endfunction

  // Narrow the extended sum to WIDTH bits.
  // The saturating build clamps toward the sign of the true result, which
  // raw[WIDTH] still holds.
  function automatic logic signed [WIDTH-1:0] narrow(
    input logic signed [WIDTH:0] raw
  );
`ifdef FIP_ADDSUB_SAT_EN
    if (ovf_of(raw)) begin
      if (raw[WIDTH]) begin
        return {1'b1, {(WIDTH-1){1'b0}}};
      end
      return {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    return raw[WIDTH-1:0];
  endfunction

  logic                    adv1;
  logic                    adv2;
  logic signed [WIDTH:0]   raw_p1;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] res_p2;
  logic                    ovf_p2;
  logic                    vld_p2;
  logic                    out_xfer;

  // A stage may load when it is empty or when the stage after it is moving.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = resetn && adv1;

  // ---- stage 1: extended sum/difference ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      raw_p1 <= '0;
    end else if (adv1) begin
      vld_p1 <= in_valid && in_ready;
      raw_p1 <= add_sub(in_x, in_y, in_sub);
    end
  end

  // ---- stage 2: overflow detect, narrow, present to consumer ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      res_p2 <= narrow(raw_p1);
      ovf_p2 <= ovf_of(raw_p1);
    end
  end

  assign out_valid = vld_p2;
  assign out_res   = res_p2;
  assign out_ovf   = ovf_p2;
  assign out_xfer  = vld_p2 && out_ready;

  // Counts delivered overflowed results only. It sticks at all-ones. A clear
  // in the same cycle as an event drops that event.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_xfer && ovf_p2 && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fip_addsub_pipe.sv
module tb_fip_addsub_pipe;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_y;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic          out_ovf;
  logic [CW-1:0] ovf_cnt;
  logic          ovf_clr;

  fip_addsub_pipe #(.WIDTH(W), .FRAC(16), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_ovf(out_ovf),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            armed = 0;
  logic [CW-1:0] exp_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic logic [W-1:0] pick(logic [W-1:0] wrap_v, logic [W-1:0] sat_v);
`ifdef FIP_ADDSUB_SAT_EN
    return sat_v;
`else
    return wrap_v;
`endif
  endfunction

  // Reference: exact integer arithmetic, then range test against WIDTH bits.
  task automatic ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic sub, output logic [W-1:0] res,
                           output logic ovf);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = sub ? sx - sy : sx + sy;
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    res = r[W-1:0];
`ifdef FIP_ADDSUB_SAT_EN
    if (ovf) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
  endtask

  // Present one operation; push its expectation at the negedge before the
  // accepting edge.
  task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input logic [W-1:0] er,
                          input logic eo, input bit lat);
    bit done;
    exp_t e;
    in_valid = 1'b1; in_x = x; in_y = y; in_sub = sub;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready && resetn) begin
        e.res = er; e.ovf = eo; e.cyc = cyc; e.lat = lat;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic send_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub);
    logic [W-1:0] r;
    logic o;
    ref_model(x, y, sub, r, o);
    send_exp(x, y, sub, r, o, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    bit done;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Monitor: scoreboard pop/compare, hold-under-stall, overflow counter model.
  bit           prev_stall = 0;
  logic [W-1:0] prev_res;
  logic         prev_ovf;
  exp_t         got;
  bit           ev_ovf;

  always @(negedge clk) begin
    if (armed) begin
      chk("ovf_cnt", ovf_cnt, exp_cnt);
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_res_held", out_res, prev_res);
        chk("stall_ovf_held", out_ovf, prev_ovf);
      end
      ev_ovf = 0;
      if (resetn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          got = sb.pop_front();
          chk("out_res", out_res, got.res);
          chk("out_ovf", out_ovf, got.ovf);
          if (got.lat) chk("latency", cyc - got.cyc, 2);
          ev_ovf = got.ovf;
        end
      end
      prev_stall = resetn && out_valid && !out_ready;
      prev_res   = out_res;
      prev_ovf   = out_ovf;
    end
    if (!resetn || ovf_clr) exp_cnt = '0;
    else if (ev_ovf && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  end

  task automatic check_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
  endtask

  initial begin
    bit seen;
    resetn = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    resetn = 1'b1;
    armed = 1;

    // Directed arithmetic cases.
    send_exp(32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0002_0000, 1'b0, 1'b1);
    send_exp(32'h7FFF_FFFF, 32'h0001_0000, 1'b0,
             pick(32'h8000_FFFF, 32'h7FFF_FFFF), 1'b1, 1'b1);
    drain();
    chk("ovf_cnt_after_first", ovf_cnt, 1);
    send_exp(32'h8000_0000, 32'h0000_0001, 1'b1,
             pick(32'h7FFF_FFFF, 32'h8000_0000), 1'b1, 1'b1);
    send_exp(32'h0002_0000, 32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b1);
    send_exp(32'h0000_0000, 32'h8000_0000, 1'b1,
             pick(32'h8000_0000, 32'h7FFF_FFFF), 1'b1, 1'b1);
    send_exp(32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFE_FFFF, 1'b0, 1'b1);
    drain();

    // Backpressure: 8 back-to-back ops, consumer stalls for 4 edges.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_ref($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random consumer stalls and input bubbles.
    fork
      begin
        repeat (400) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 200; i++) begin
          send_ref(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
    join
    drain();

    // Reset with two operations in flight.
    send_ref(32'h0000_1234, 32'h0000_0001, 1'b0);
    send_ref(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    resetn = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_no_valid", out_valid, 0);
    end
    @(posedge clk); #1;

    // Counter saturation.
    for (int i = 0; i < 18; i++)
      send_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0,
               pick(32'hFFFF_FFFE, 32'h7FFF_FFFF), 1'b1, 1'b0);
    drain();
    chk("ovf_cnt_saturated", ovf_cnt, {CW{1'b1}});

    // Clear coinciding with an overflow transfer.
    out_ready = 1'b0;
    send_ref(32'h8000_0000, 32'h0000_0001, 1'b1);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("clr_result_present", seen, 1);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cnt_clr_priority", ovf_cnt, 0);
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
